// File: rtl/i2s_slave_rx_pkg.sv
// Shared I2S receive constants, channel codes and receiver state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2s_slave_rx_pkg;

  localparam int DATA_BITS    = 24;   // data bits per slot, MSB first
  localparam int SLOT_BITS    = 32;   // BCLK cycles per LRCLK half-period
  localparam int LOCK_SLOTS   = 4;    // consecutive good slots before locked
  localparam int TIMEOUT_CLKS = 256;  // clk cycles without BCLK rise before resync

  localparam int CNT_W  = 6;                          // bit counter, saturates at 63
  localparam int GOOD_W = $clog2(LOCK_SLOTS + 1);     // good-slot counter
  localparam int TO_W   = $clog2(TIMEOUT_CLKS + 1);   // timeout counter

  localparam logic I2S_LEFT  = 1'b0;
  localparam logic I2S_RIGHT = 1'b1;

  typedef enum logic {
    UNSYNC  = 1'b0,
    RECEIVE = 1'b1
  } rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// 2-FF synchronizer for one asynchronous pin, plus an edge register for rise/fall flags.
// Latency: sync is 2 clk behind the pin; rise/fall are combinational from the sync/edge regs.
// Backpressure: none; free-running sampler.
// Ports: clk, rst (async active-high), din (async pin) -> sync (2nd FF), rise, fall (1-clk flags).
module i2s_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic ff1;
  logic ff2;
  logic edge_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1    <= 1'b0;
      ff2    <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      ff1    <= din;
      ff2    <= ff1;
      edge_q <= ff2;
    end
  end

  assign sync = ff2;
  assign rise = ff2 & ~edge_q;
  assign fall = ~ff2 & edge_q;

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S target receiver: oversamples BCLK/LRCLK/SDATA on clk, deserializes left/right words.
// Latency: word valid <= 4 clk after the last data-bit BCLK rise at the pin.
// Backpressure: none; valid/frame_err are single-cycle pulses, data held until next word.
// Ports: clk, rst (async active-high), i2s_bclk/i2s_lrclk/i2s_sdata (async pins)
//        -> left_data/left_valid, right_data/right_valid, frame_err, locked.
module i2s_slave_rx
  import i2s_slave_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i2s_bclk,
  input  logic                 i2s_lrclk,
  input  logic                 i2s_sdata,
  output logic [DATA_BITS-1:0] left_data,
  output logic                 left_valid,
  output logic [DATA_BITS-1:0] right_data,
  output logic                 right_valid,
  output logic                 frame_err,
  output logic                 locked
);

  logic bclk_sync_unused, bclk_fall_unused, rise_evt;
  logic lr_s, lr_rise_unused, lr_fall_unused;
  logic sd_s, sd_rise_unused, sd_fall_unused;

  // Equal sync depth on all pins keeps LRCLK/SDATA aligned with the BCLK rise flag.
  i2s_sync_edge u_bclk (.clk(clk), .rst(rst), .din(i2s_bclk),
                        .sync(bclk_sync_unused), .rise(rise_evt), .fall(bclk_fall_unused));
  i2s_sync_edge u_lr   (.clk(clk), .rst(rst), .din(i2s_lrclk),
                        .sync(lr_s), .rise(lr_rise_unused), .fall(lr_fall_unused));
  i2s_sync_edge u_sd   (.clk(clk), .rst(rst), .din(i2s_sdata),
                        .sync(sd_s), .rise(sd_rise_unused), .fall(sd_fall_unused));

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt;
  logic [CNT_W-1:0]      next_cnt;
  logic [DATA_BITS-1:0]  shift_q;
  logic [GOOD_W-1:0]     good_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  prev_lr;
  // prev_lr is meaningless until one BCLK rise has been seen since reset/timeout;
  // without this, the first rise after release could fake a slot start mid-slot.
  logic                  lr_seen;
  logic                  slot_start;
  logic                  timeout;
  logic                  receiving;

  assign receiving  = (state_q == RECEIVE);
  assign slot_start = rise_evt & lr_seen & (lr_s != prev_lr);
  assign timeout    = ~rise_evt & (to_cnt == TO_W'(TIMEOUT_CLKS - 1));
  assign next_cnt   = (bit_cnt == {CNT_W{1'b1}}) ? bit_cnt : bit_cnt + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    if (timeout)
      state_d = UNSYNC;
    else if (slot_start)
      state_d = RECEIVE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= UNSYNC;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      good_cnt    <= '0;
      to_cnt      <= '0;
      prev_lr     <= 1'b0;
      lr_seen     <= 1'b0;
      left_data   <= '0;
      left_valid  <= 1'b0;
      right_data  <= '0;
      right_valid <= 1'b0;
      frame_err   <= 1'b0;
      locked      <= 1'b0;
    end else begin
      left_valid  <= 1'b0;
      right_valid <= 1'b0;
      frame_err   <= 1'b0;

      // Saturate at TIMEOUT_CLKS so the timeout fires once per BCLK stall.
      if (rise_evt)
        to_cnt <= '0;
      else if (to_cnt != TO_W'(TIMEOUT_CLKS))
        to_cnt <= to_cnt + TO_W'(1);

      if (timeout) begin
        good_cnt <= '0;
        locked   <= 1'b0;
        lr_seen  <= 1'b0;
        bit_cnt  <= '0;
      end

      if (rise_evt) begin
        prev_lr <= lr_s;
        lr_seen <= 1'b1;
        if (slot_start) begin
          // This rise is the delay bit of the new slot: counted as bit 0, not shifted.
          bit_cnt <= '0;
          if (receiving) begin
            if (bit_cnt == CNT_W'(SLOT_BITS - 1)) begin
              if (good_cnt != GOOD_W'(LOCK_SLOTS))
                good_cnt <= good_cnt + GOOD_W'(1);
              if (good_cnt >= GOOD_W'(LOCK_SLOTS - 1))
                locked <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              good_cnt  <= '0;
              locked    <= 1'b0;
            end
          end
        end else if (receiving) begin
          bit_cnt <= next_cnt;
          if (next_cnt <= CNT_W'(DATA_BITS))
            shift_q <= {shift_q[DATA_BITS-2:0], sd_s};
          if (next_cnt == CNT_W'(DATA_BITS)) begin
            if (lr_s == I2S_LEFT) begin
              left_data  <= {shift_q[DATA_BITS-2:0], sd_s};
              left_valid <= 1'b1;
            end else begin
              right_data  <= {shift_q[DATA_BITS-2:0], sd_s};
              right_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
